dc_req_fifo: RTL and testbench

- Request queue that directly consumes the index extractor's FIFO-write interface (write enable, 128-bit packed entry) and returns almost-full backpressure to it.
- Buffers read/write requests and presents them to the downstream tag-lookup stage through a first-word-fall-through valid/ready port.
- Pre-decodes the entry into write flag, ID and address fields for the consumer.

---
 rtl/dc_pkg.sv | 24 ++
 rtl/dc_fifo_mem.sv | 24 ++
 rtl/dc_req_fifo.sv | 130 +++++++++++++
 tb/tb_dc_req_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// Shared request-path definitions: entry field layout, request type and
// default widths used by the index extractor and the request FIFO.
package dc_pkg;

  localparam int DC_ADDR_WIDTH = 64;
  localparam int DC_ID_WIDTH   = 16;
  localparam int DC_DATA_WIDTH = 128;

  // Packed entry layout: [WR_BIT] flag, then ID, then address; rest unused.
  localparam int WR_BIT   = 0;
  localparam int ID_LSB   = 1;
  localparam int ADDR_LSB = DC_ID_WIDTH + 1;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_e;

  // Address offset for a non-default ID width.
  function automatic int addr_lsb(input int id_w);
    return id_w + 1;
  endfunction

endpackage

// File: rtl/dc_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
// Contents are never reset; validity is tracked by the owner's pointers.
module dc_fifo_mem #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  // Write the addressed row on an accepted push.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dc_req_fifo.sv
// Request queue between the index extractor and the tag-lookup stage.
// First-word-fall-through dequeue port with pre-decoded entry fields and
// registered almost-full backpressure.
// Optional build macro DC_REQ_FIFO_STATS_EN adds a sticky overflow flag
// (ovf_o) and an occupancy high-water mark (hwm_o).
module dc_req_fifo
  import dc_pkg::*;
#(
  parameter int ADDR_WIDTH   = DC_ADDR_WIDTH,
  parameter int ID_WIDTH     = DC_ID_WIDTH,
  parameter int DATA_WIDTH   = DC_DATA_WIDTH,  // >= ADDR_WIDTH+ID_WIDTH+1
  parameter int DEPTH        = 16,             // power of two, >= 4
  parameter int AFULL_MARGIN = 2               // 1..DEPTH-1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  output logic                       afull_o,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [DATA_WIDTH-1:0]      deq_data_o,
  output logic                       deq_wr_o,
  output logic [ID_WIDTH-1:0]        deq_id_o,
  output logic [ADDR_WIDTH-1:0]      deq_addr_o,
`ifdef DC_REQ_FIFO_STATS_EN
  output logic                       ovf_o,
  output logic [$clog2(DEPTH):0]     hwm_o,
`endif
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int A_LSB = addr_lsb(ID_WIDTH);
  localparam logic [PW-1:0] AFULL_TH = PW'(DEPTH - AFULL_MARGIN);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;
  logic          afull_q,  afull_d;
  logic          full, empty, push, pop;

  // Wrap bit distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign deq_valid_o = !empty;
  assign pop  = deq_valid_o && deq_ready_i;
  // A pop frees the slot this same edge, so a full queue still takes a push.
  assign push = wr_en_i && (!full || pop);

  // Next-state pointers, occupancy and almost-full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
    // From next-state count so backpressure is on time with the occupancy.
    afull_d = (count_d >= AFULL_TH);
  end

  // Pointer and flag state; reset discards all entries at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
    end
  end

  assign count_o = count_q;
  assign afull_o = afull_q;

  dc_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (deq_data_o)
  );

  // Decoded head fields are plain slices; meaningless while deq_valid_o=0.
  assign deq_wr_o   = (req_type_e'(deq_data_o[WR_BIT]) == WRITE);
  assign deq_id_o   = deq_data_o[ID_LSB +: ID_WIDTH];
  assign deq_addr_o = deq_data_o[A_LSB +: ADDR_WIDTH];

`ifdef DC_REQ_FIFO_STATS_EN
  logic          ovf_q, ovf_d;
  logic [PW-1:0] hwm_q, hwm_d;

  // Overflow latches on any push refused while full; high-water tracks count.
  always_comb begin
    ovf_d = ovf_q | (wr_en_i && !push);
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      hwm_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      hwm_q <= hwm_d;
    end
  end

  assign ovf_o = ovf_q;
  assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_dc_req_fifo.sv
// Self-checking bench for dc_req_fifo: directed cases plus randomized
// push/pop against a queue-based reference model.
module tb_dc_req_fifo;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
  localparam int PW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [127:0]  wr_data;
  logic          afull;
  logic          deq_valid;
  logic          deq_ready;
  logic [127:0]  deq_data;
  logic          deq_wr;
  logic [15:0]   deq_id;
  logic [63:0]   deq_addr;
  logic [PW-1:0] count;
`ifdef DC_REQ_FIFO_STATS_EN
  logic          ovf;
  logic [PW-1:0] hwm;
`endif

  always #5 clk = ~clk;

  dc_req_fifo #(
    .ADDR_WIDTH(64), .ID_WIDTH(16), .DATA_WIDTH(128),
    .DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .afull_o     (afull),
    .deq_valid_o (deq_valid),
    .deq_ready_i (deq_ready),
    .deq_data_o  (deq_data),
    .deq_wr_o    (deq_wr),
    .deq_id_o    (deq_id),
    .deq_addr_o  (deq_addr),
`ifdef DC_REQ_FIFO_STATS_EN
    .ovf_o       (ovf),
    .hwm_o       (hwm),
`endif
    .count_o     (count)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: ordered list of stored entries plus statistics.
  logic [127:0] mq[$];
  int           m_hwm;
  bit           m_ovf;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic wr, input logic [15:0] id, input logic [63:0] addr);
    logic [127:0] e;
    e = {$urandom, $urandom, $urandom, $urandom};
    e[0]     = wr;
    e[16:1]  = id;
    e[80:17] = addr;
    return e;
  endfunction

  task automatic check_outputs();
    logic [127:0] h;
    chk("valid", deq_valid, mq.size() != 0);
    chk("count", count, mq.size());
    chk("afull", afull, mq.size() >= DEPTH - MARGIN);
    if (mq.size() != 0) begin
      h = mq[0];
      chk("data", deq_data, h);
      chk("wr",   deq_wr,   h[0]);
      chk("id",   deq_id,   h[16:1]);
      chk("addr", deq_addr, h[80:17]);
    end
`ifdef DC_REQ_FIFO_STATS_EN
    chk("ovf", ovf, m_ovf);
    chk("hwm", hwm, m_hwm);
`endif
  endtask

  // One clock: drive, check pre-edge state, then advance the model.
  task automatic step(input logic we, input logic [127:0] wd, input logic rdy);
    bit do_pop, do_push;
    wr_en = we; wr_data = wd; deq_ready = rdy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    do_pop  = (mq.size() != 0) && rdy;
    do_push = we && ((mq.size() < DEPTH) || do_pop);
    if (we && !do_push) m_ovf = 1'b1;
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(wd);
    if (mq.size() > m_hwm) m_hwm = mq.size();
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0; deq_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete(); m_hwm = 0; m_ovf = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; deq_ready = 1'b0;
    mq.delete(); m_hwm = 0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    chk("rst_valid", deq_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_afull", afull, 1'b0);

    // Single read entry appears one cycle later with decoded fields.
    step(1'b1, mk(1'b0, 16'h00A5, 64'h1234), 1'b0);
    chk("one_valid", deq_valid, 1'b1);
    chk("one_wr",    deq_wr,    1'b0);
    chk("one_id",    deq_id,    16'h00A5);
    chk("one_addr",  deq_addr,  64'h1234);
    chk("one_count", count,     1);
    step(1'b0, '0, 1'b1);

    // Fill to full; afull rises with the 14th push.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, mk(1'b1, 16'(i), 64'(i * 64)), 1'b0);
      chk("fill_afull", afull, (i + 1) >= DEPTH - MARGIN);
    end
    chk("full_count", count, DEPTH);
    step(1'b1, mk(1'b1, 16'hDEAD, 64'h0), 1'b0);
    chk("drop_count", count, DEPTH);
    chk("drop_head", deq_id, 16'h0000);
`ifdef DC_REQ_FIFO_STATS_EN
    chk("drop_ovf", ovf, 1'b1);
`endif

    // Full with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      chk("wrap_id", deq_id, 16'(i));
      step(1'b1, mk(1'b0, 16'(DEPTH + i), 64'(i)), 1'b1);
      chk("wrap_count", count, DEPTH);
    end

    // Drain, then pop requests on empty do nothing.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1);
      chk("empty_valid", deq_valid, 1'b0);
      chk("empty_count", count, 0);
    end
    step(1'b1, mk(1'b1, 16'h0055, 64'h99), 1'b0);
    chk("after_empty_id", deq_id, 16'h0055);
    step(1'b0, '0, 1'b1);

    // Reset mid-operation discards contents.
    for (int i = 0; i < 8; i++) step(1'b1, mk(1'b0, 16'(16'h100 + i), 64'(i)), 1'b0);
    do_reset();
    chk("mrst_count", count, 0);
    chk("mrst_valid", deq_valid, 1'b0);
    chk("mrst_afull", afull, 1'b0);
    step(1'b1, mk(1'b0, 16'h0007, 64'h77), 1'b0);
    chk("mrst_id", deq_id, 16'h0007);
    chk("mrst_cnt1", count, 1);
    step(1'b0, '0, 1'b1);

    // Randomized traffic against the model, checked every cycle.
    for (int i = 0; i < 1000; i++) begin
      logic we, rdy;
      we  = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 70 : 35));
      rdy = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 40 : 75));
      step(we, mk(1'($urandom), 16'($urandom), {$urandom, $urandom}), rdy);
    end
    @(negedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
